// File: rtl/mac_stop_mult_pkg.sv
// Shared types and default sizing for the stoppable matrix multiply-accumulate sequencer.
package mac_stop_pkg;

    localparam int DEF_M = 4;
    localparam int DEF_N = 4;
    localparam int DEF_K = 4;
    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } mac_state_e;

    // Keeps index ports at least one bit wide when a dimension is 1.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_mult_addr_counter.sv
// Nested i/j/k element-pair counter: k innermost, then j, then i; all wrap to 0 after the last pair.
module mac_addr_counter
    import mac_stop_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int N  = DEF_N,
    parameter int K  = DEF_K,
    localparam int MW = addr_width(M),
    localparam int NW = addr_width(N),
    localparam int KW = addr_width(K)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          advance_i,
    output logic [MW-1:0] i_o,
    output logic [KW-1:0] k_o,
    output logic [NW-1:0] j_o,
    output logic          last_o
);

    logic [MW-1:0] i_q, i_d;
    logic [KW-1:0] k_q, k_d;
    logic [NW-1:0] j_q, j_d;
    logic          i_wrap, j_wrap, k_wrap;

    assign k_wrap = (k_q == KW'(K - 1));
    assign j_wrap = (j_q == NW'(N - 1));
    assign i_wrap = (i_q == MW'(M - 1));
    assign last_o = i_wrap && j_wrap && k_wrap;

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path leaves it unassigned (no latch).
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (advance_i) begin
            k_d = k_wrap ? '0 : k_q + 1'b1;
            if (k_wrap) begin
                j_d = j_wrap ? '0 : j_q + 1'b1;
                if (j_wrap) begin
                    i_d = i_wrap ? '0 : i_q + 1'b1;
                end
            end
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;
    assign k_o = k_q;

endmodule

// File: rtl/mac_stop_mult.sv
// Issues every A[i][k]/B[k][j] read pair, multiplies the returned operands and
// strobes each product; do_mac low freezes issue and the multiply pipeline in place.
module mac_stop_mult
    import mac_stop_pkg::*;
#(
    parameter int M                        = DEF_M,
    parameter int N                        = DEF_N,
    parameter int K                        = DEF_K,
    parameter int DATA_WIDTH_INIT_MATRIX   = DEF_W,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
    localparam int W  = DATA_WIDTH_INIT_MATRIX,
    localparam int MW = addr_width(M),
    localparam int NW = addr_width(N),
    localparam int KW = addr_width(K)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [W-1:0]    data_in_a,
    input  logic [W-1:0]    data_in_b,
    input  logic            do_mac,
    output logic [MW-1:0]   row_addr_a,
    output logic [KW-1:0]   col_addr_a,
    output logic [KW-1:0]   row_addr_b,
    output logic [NW-1:0]   col_addr_b,
    output logic            matrix_a_re,
    output logic            matrix_b_re,
    output logic [2*W-1:0]  product_reg,
    output logic            mult_done_reg,
    output logic            mac_done,
    output logic [MW-1:0]   matrix_a_row_addr_counter_reg,
    output logic [KW-1:0]   matrix_a_col_addr_counter_reg,
    output logic [KW-1:0]   matrix_b_row_addr_counter_reg,
    output logic [NW-1:0]   matrix_b_col_addr_counter_reg
);

    if (DATA_WIDTH_RESULT_MATRIX < 2 * DATA_WIDTH_INIT_MATRIX) begin : g_width_check
        $error("mac_stop_mult: DATA_WIDTH_RESULT_MATRIX narrower than a full product");
    end

    mac_state_e     state_q;
    logic           valid_q;
    logic           mult_done_q;
    logic           mac_done_q;
    logic [2*W-1:0] product_q;

    logic           issue;
    logic           run;
    logic           cnt_last;
    logic [MW-1:0]  cnt_i;
    logic [KW-1:0]  cnt_k;
    logic [NW-1:0]  cnt_j;

    assign issue = do_mac && (state_q == ST_ISSUE);
    assign run   = do_mac && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    mac_addr_counter #(
        .M (M),
        .N (N),
        .K (K)
    ) u_addr_counter (
        .clk       (clk),
        .resetn    (resetn),
        .advance_i (issue),
        .i_o       (cnt_i),
        .k_o       (cnt_k),
        .j_o       (cnt_j),
        .last_o    (cnt_last)
    );

    // valid_q marks operands on data_in_* this cycle; a stall holds it, since the RAMs hold their data while re is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            mult_done_q <= 1'b0;
            mac_done_q  <= 1'b0;
            product_q   <= '0;
        end else begin
            if (run) begin
                valid_q     <= issue;
                mult_done_q <= valid_q;
                if (valid_q) begin
                    product_q <= (2*W)'(data_in_a) * (2*W)'(data_in_b);
                end
            end else begin
                mult_done_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE:  if (do_mac) state_q <= ST_ISSUE;
                ST_ISSUE: if (do_mac && cnt_last) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    // The final product was registered on the previous edge once valid_q has cleared.
                    if (do_mac && !valid_q) begin
                        state_q    <= ST_DONE;
                        mac_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!do_mac) begin
                        state_q    <= ST_IDLE;
                        mac_done_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign matrix_a_re = issue;
    assign matrix_b_re = issue;
    assign row_addr_a  = cnt_i;
    assign col_addr_a  = cnt_k;
    assign row_addr_b  = cnt_k;
    assign col_addr_b  = cnt_j;

    assign product_reg   = product_q;
    assign mult_done_reg = mult_done_q;
    assign mac_done      = mac_done_q;

    assign matrix_a_row_addr_counter_reg = cnt_i;
    assign matrix_a_col_addr_counter_reg = cnt_k;
    assign matrix_b_row_addr_counter_reg = cnt_k;
    assign matrix_b_col_addr_counter_reg = cnt_j;

endmodule

// File: tb/tb_mac_stop_mult.sv
// Self-checking bench for mac_stop_mult: behavioural RAMs plus a product-stream reference model.
module tb_mac_stop_mult;
    import mac_stop_pkg::*;

    localparam int M = 4;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic           do_mac;
    logic [W-1:0]   data_in_a = '0;
    logic [W-1:0]   data_in_b = '0;
    logic [1:0]     row_addr_a, col_addr_a, row_addr_b, col_addr_b;
    logic           matrix_a_re, matrix_b_re;
    logic [2*W-1:0] product_reg;
    logic           mult_done_reg, mac_done;
    logic [1:0]     a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt;

    mac_stop_mult #(
        .M (M), .N (N), .K (K), .DATA_WIDTH_INIT_MATRIX (W)
    ) dut (
        .clk                           (clk),
        .resetn                        (resetn),
        .data_in_a                     (data_in_a),
        .data_in_b                     (data_in_b),
        .do_mac                        (do_mac),
        .row_addr_a                    (row_addr_a),
        .col_addr_a                    (col_addr_a),
        .row_addr_b                    (row_addr_b),
        .col_addr_b                    (col_addr_b),
        .matrix_a_re                   (matrix_a_re),
        .matrix_b_re                   (matrix_b_re),
        .product_reg                   (product_reg),
        .mult_done_reg                 (mult_done_reg),
        .mac_done                      (mac_done),
        .matrix_a_row_addr_counter_reg (a_row_cnt),
        .matrix_a_col_addr_counter_reg (a_col_cnt),
        .matrix_b_row_addr_counter_reg (b_row_cnt),
        .matrix_b_col_addr_counter_reg (b_col_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs: data appears the cycle after re and holds while re is low.
    logic [W-1:0] a_mem [M][K];
    logic [W-1:0] b_mem [K][N];

    always @(posedge clk) begin
        if (matrix_a_re) data_in_a <= a_mem[row_addr_a][col_addr_a];
        if (matrix_b_re) data_in_b <= b_mem[row_addr_b][col_addr_b];
    end

    logic [2*W-1:0] got_q [$];
    logic [2*W-1:0] exp_q [$];

    always @(negedge clk) begin
        if (resetn === 1'b1 && mult_done_reg === 1'b1) got_q.push_back(product_reg);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++) a_mem[r][c] = $urandom;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++) b_mem[r][c] = $urandom;
    endtask

    // Reference: the product of every (i, j, k) pair in k-innermost, then j, then i order.
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < K; k++)
                    exp_q.push_back(64'(a_mem[i][k]) * 64'(b_mem[k][j]));
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++)
            check($sformatf("%s_pair%0d", tag, n), got_q[n], exp_q[n]);
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && mac_done !== 1'b1; c++) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mac_done"},  mac_done,      1'b0);
        check({tag, "_mult_done"}, mult_done_reg, 1'b0);
        check({tag, "_product"},   product_reg,   64'h0);
        check({tag, "_re"},        {matrix_a_re, matrix_b_re}, 2'b00);
        check({tag, "_addr"},      {row_addr_a, col_addr_a, row_addr_b, col_addr_b}, 8'h00);
        check({tag, "_counters"},  {a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt}, 8'h00);
    endtask

    logic [7:0]     frozen;
    logic [2*W-1:0] first_four [4];

    initial begin
        first_four = '{64'd6, 64'd2, 64'd15, 64'd4};
        resetn = 1'b0;
        do_mac = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Run 1: full sequence with known leading row/column and a 3-cycle stop mid-run.
        fill_random();
        a_mem[0] = '{32'd6, 32'd2, 32'd5, 32'd2};
        b_mem[0][0] = 32'd1;
        b_mem[1][0] = 32'd1;
        b_mem[2][0] = 32'd3;
        b_mem[3][0] = 32'd2;
        build_expected();
        got_q.delete();
        @(negedge clk);
        do_mac = 1'b1;
        repeat (30) @(negedge clk);

        frozen = {a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt};
        do_mac = 1'b0;
        #1;
        check("stall_re_drop", {matrix_a_re, matrix_b_re}, 2'b00);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("stall_counters%0d", s), {a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt}, frozen);
            check($sformatf("stall_no_strobe%0d", s), mult_done_reg, 1'b0);
        end
        do_mac = 1'b1;

        wait_done(300);
        check("run1_mac_done", mac_done, 1'b1);
        check("run1_re_low", {matrix_a_re, matrix_b_re}, 2'b00);
        check("run1_counters_zero", {a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt}, 8'h00);
        for (int n = 0; n < 4 && n < got_q.size(); n++)
            check($sformatf("first_four%0d", n), got_q[n], first_four[n]);
        compare_stream("run1");

        repeat (3) @(negedge clk);
        check("done_hold_mac_done", mac_done, 1'b1);
        check("done_no_reissue", {matrix_a_re, matrix_b_re}, 2'b00);
        check("done_no_extra_strobes", got_q.size(), M * N * K);
        do_mac = 1'b0;
        @(negedge clk);
        check("done_to_idle", mac_done, 1'b0);

        // Run 2: all-ones operands first, then an asynchronous reset once 20 pairs have completed.
        fill_random();
        a_mem[0][0] = 32'hFFFF_FFFF;
        b_mem[0][0] = 32'hFFFF_FFFF;
        got_q.delete();
        do_mac = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < 20; c++) @(negedge clk);
        check("pair20_reached", got_q.size() >= 20, 1'b1);
        if (got_q.size() > 0) check("max_operands", got_q[0], 64'hFFFF_FFFE_0000_0001);
        resetn = 1'b0;
        do_mac = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        @(negedge clk);
        resetn = 1'b1;

        // Run 3: a fresh run after the abort starts again at A[0][0], B[0][0].
        fill_random();
        build_expected();
        got_q.delete();
        @(negedge clk);
        do_mac = 1'b1;
        @(negedge clk);
        check("restart_re", {matrix_a_re, matrix_b_re}, 2'b11);
        check("restart_addr", {row_addr_a, col_addr_a, row_addr_b, col_addr_b}, 8'h00);
        wait_done(300);
        check("run3_mac_done", mac_done, 1'b1);
        compare_stream("run3");
        do_mac = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stop_mult.md
MAC_STOP_MULT -- requirements
Module: mac_stop_mult

Interface
REQ-001 SHALL have parameter M, default 4: rows of matrix A and of the result.
REQ-002 SHALL have parameter N, default 4: columns of matrix B and of the result.
REQ-003 SHALL have parameter K, default 4: inner dimension (A columns = B rows).
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX, default 32: operand width W.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX, default 2*W+$clog2(K): accumulator width for the downstream adder; unused internally apart from the width check.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk, input, 1, all flops rise-edge; resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have the ports data_in_a and data_in_b: input, W each, A and B element read data.
REQ-008 SHALL have the port do_mac: input, 1, run enable; low = stop/pause.
REQ-009 SHALL have the ports row_addr_a and col_addr_a: output, $clog2(M) and $clog2(K), A read address.
REQ-010 SHALL have the ports row_addr_b and col_addr_b: output, $clog2(K) and $clog2(N), B read address.
REQ-011 SHALL have the ports matrix_a_re and matrix_b_re: output, 1 each, read enables.
REQ-012 SHALL have the port product_reg: output, 2W, registered product.
REQ-013 SHALL have the port mult_done_reg: output, 1, product_reg valid strobe.
REQ-014 SHALL have the port mac_done: output, 1, whole sequence finished.
REQ-015 SHALL have the counter-register output ports matrix_a_row_addr_counter_reg ($clog2(M)), matrix_a_col_addr_counter_reg ($clog2(K)), matrix_b_row_addr_counter_reg ($clog2(K)) and matrix_b_col_addr_counter_reg ($clog2(N)).

Function
REQ-016 SHALL sequence all M*N*K element pairs A[i][k], B[k][j]; k innermost, then j, then i (i=row_a, k=col_a=row_b, j=col_b).
REQ-017 SHALL run the FSM states IDLE -> ISSUE -> DRAIN -> DONE.
REQ-018 SHALL move IDLE -> ISSUE when do_mac=1.
REQ-019 SHALL move DONE -> IDLE when do_mac=0.
REQ-020 In ISSUE with do_mac=1, SHALL assert matrix_a_re=matrix_b_re=1, drive the addresses from the counters (combinationally) and advance the counters at the clock edge.
REQ-021 SHALL wrap each counter to 0 at its limit and carry into the next counter.
REQ-022 When do_mac=0 in ISSUE or DRAIN, SHALL hold the counters, deassert re and stall the pipeline (stop).
REQ-023 SHALL treat read data as valid one cycle after re.
REQ-024 SHALL register product_reg <= data_in_a*data_in_b, unsigned, full 2W bits, no truncation.
REQ-025 SHALL pulse mult_done_reg high for the same cycle the new product_reg appears, i.e. 2 cycles after its re.
REQ-026 After issuing (M-1,N-1,K-1), SHALL drop re in DRAIN until the last product is registered, then enter DONE.
REQ-027 SHALL hold mac_done=1 throughout DONE, with the counters back at 0.
REQ-028 SHALL keep re low and accept no new issue while in DONE.
REQ-029 SHALL make the counter-register outputs the live counters (A row=i, A col=k, B row=k, B col=j).
REQ-030 SHALL hold product_reg between strobes.

Reset
REQ-031 SHALL asynchronously force IDLE while resetn=0, with all counters, addresses, re, product_reg, mult_done_reg and mac_done at 0.
REQ-032 Reset mid-run SHALL abort the sequence; the next do_mac restarts at (0,0,0).

Structure
REQ-033 SHALL place the FSM state enum and the default parameter constants in a shared package, mac_stop_pkg.
REQ-034 SHALL implement the i/j/k nested counter as one sub-module, mac_addr_counter; the multiplier and FSM SHALL stay inline.

Verification
REQ-035 Bench SHALL cover: resetn low -> all outputs 0, mac_done=0.
REQ-036 Bench SHALL cover: A row0={6,2,5,2}, B col0={1,1,3,2}, do_mac held -> first four product_reg strobes 6,2,15,4.
REQ-037 Bench SHALL cover: full 4x4x4 run, do_mac held -> exactly 64 mult_done_reg pulses, then mac_done=1 and all re low.
REQ-038 Bench SHALL cover: do_mac dropped for 3 cycles mid-run -> counters frozen, no strobes, resumes with no skipped or duplicated pair.
REQ-039 Bench SHALL cover: operands 0xFFFFFFFF x 0xFFFFFFFF -> product_reg=0xFFFFFFFE00000001.
REQ-040 Bench SHALL cover: resetn pulsed at pair 20 -> outputs 0; a new do_mac run starts at A[0][0], B[0][0].
